// File: rtl/result_byte_serializer.sv
// result_byte_serializer: buffers 32-bit results in a word FIFO and streams each word LSB-first onto the 8-bit pad bus
//   Build option: define SERIALIZER_CHECKSUM_EN to append an XOR checksum byte (b0^b1^b2^b3) to every word.
//   Ports:
//     clock, resetb               single clock, asynchronous active-low reset
//     in_data, in_valid, in_ready word input handshake; in_ready is the inverted registered full flag
//     io_out, io_oeb              byte driven to mprj_io[7:0] and its output-enable bar (0 = driven)
//     byte_strobe                 pulse on the first cycle of every byte
//     word_start                  pulse on the first cycle of byte 0 of each word
//     busy                        a word is being sent or words are still queued
module result_byte_serializer #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  io_out,
   output logic [7:0]  io_oeb,
   output logic        byte_strobe,
   output logic        word_start,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND
`ifdef SERIALIZER_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [31:0]   word_q, word_d;
   logic [7:0]    io_out_q, io_out_d;
   logic [7:0]    io_oeb_q;
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   head;
   logic          empty, full, push, pop, last_hold, word_done;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty     = wr_ptr_q == rd_ptr_q;
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push      = in_valid && !full;
   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   assign last_hold = hold_cnt_q == HOLD_LAST;

`ifdef SERIALIZER_CHECKSUM_EN
   logic [7:0] csum;
   assign csum = word_q[7:0] ^ word_q[15:8] ^ word_q[23:16] ^ word_q[31:24];
`endif

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      hold_cnt_d = hold_cnt_q;
      word_d     = word_q;
      io_out_d   = io_out_q;
      word_done  = 1'b0;
      pop        = 1'b0;
      case (state_q)
         SEND: begin
            hold_cnt_d = last_hold ? '0 : hold_cnt_q + 1'b1;
            if (last_hold && byte_idx_q != 2'd3) begin
               byte_idx_d = byte_idx_q + 2'd1;
               io_out_d   = 8'(word_q >> {byte_idx_q + 2'd1, 3'b000});
            end else if (last_hold) begin
`ifdef SERIALIZER_CHECKSUM_EN
               state_d  = CSUM;
               io_out_d = csum;
`else
               word_done = 1'b1;
`endif
            end
         end
`ifdef SERIALIZER_CHECKSUM_EN
         CSUM: begin
            hold_cnt_d = last_hold ? '0 : hold_cnt_q + 1'b1;
            word_done  = last_hold;
         end
`endif
         // IDLE behaves like a word that has just finished, so it shares the pop path.
         default: word_done = 1'b1;
      endcase
      if (word_done && !empty) begin
         pop        = 1'b1;
         state_d    = SEND;
         word_d     = head;
         io_out_d   = head[7:0];
         byte_idx_d = '0;
         hold_cnt_d = '0;
      end else if (word_done) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         hold_cnt_q <= '0;
         word_q     <= '0;
         io_out_q   <= '0;
         io_oeb_q   <= 8'hFF;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         hold_cnt_q <= hold_cnt_d;
         word_q     <= word_d;
         io_out_q   <= io_out_d;
         io_oeb_q   <= 8'h00;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   assign in_ready    = !full;
   assign io_out      = io_out_q;
   assign io_oeb      = io_oeb_q;
   assign byte_strobe = state_q != IDLE && hold_cnt_q == '0;
   assign word_start  = state_q == SEND && hold_cnt_q == '0 && byte_idx_q == 2'd0;
   assign busy        = state_q != IDLE || !empty;
endmodule

// File: tb/tb_result_byte_serializer.sv
// tb_result_byte_serializer: randomized and directed bench against a word-timeline reference model
module tb_result_byte_serializer;
   localparam int DEPTH = 4;
   localparam int H     = 4;
`ifdef SERIALIZER_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int L = NB * H;

   logic        clock = 1'b0, resetb = 1'b0;
   logic [31:0] in_data = '0, in_data1 = '0;
   logic        in_valid = 1'b0, in_valid1 = 1'b0;
   logic        in_ready, byte_strobe, word_start, busy;
   logic        in_ready1, byte_strobe1, word_start1, busy1;
   logic [7:0]  io_out, io_oeb, io_out1, io_oeb1;
   int          n_tests = 0, n_fail = 0, cyc = 0, rel_c = 0, last_start = -1000000;
   bit          in_rst = 1'b1;
   // Model: every accepted word with the edge it was accepted on and the cycle its byte 0 appears.
   logic [31:0] w_data[$];
   int          w_acc[$], w_start[$];

   result_byte_serializer #(.DEPTH(DEPTH), .HOLD_CYCLES(H)) dut (
      .clock(clock), .resetb(resetb), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .io_out(io_out), .io_oeb(io_oeb), .byte_strobe(byte_strobe), .word_start(word_start), .busy(busy));

   result_byte_serializer #(.DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (
      .clock(clock), .resetb(resetb), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .io_out(io_out1), .io_oeb(io_oeb1), .byte_strobe(byte_strobe1), .word_start(word_start1), .busy(busy1));

   always #5 clock = ~clock;

   function automatic logic [7:0] byte_of(input logic [31:0] w, input int j);
      logic [31:0] s;
      s = w >> (8 * j);
      return (j < 4) ? s[7:0] : (w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
   endfunction

   // Expected {io_out, io_oeb, byte_strobe, word_start, busy, in_ready} in cycle c.
   function automatic logic [19:0] expect_at(input int c);
      logic [7:0] b = 8'h00;
      logic st = 1'b0, ws = 1'b0, bz = 1'b0;
      int occ = 0;
      int k;
      for (int i = 0; i < w_data.size(); i++) begin
         if (w_start[i] <= c) begin
            k  = c - w_start[i];
            b  = byte_of(w_data[i], (k < L) ? k / H : NB - 1);
            st = (k < L) && (k % H == 0);
            ws = k == 0;
         end
         if (w_acc[i] <= c && c < w_start[i] + L) bz = 1'b1;
         if (w_acc[i] <= c && w_start[i] > c) occ++;
      end
      return {b, (in_rst || c <= rel_c) ? 8'hFF : 8'h00, st, ws, bz, occ < DEPTH};
   endfunction

   task automatic clear_model;
      w_data.delete();
      w_acc.delete();
      w_start.delete();
      last_start = -1000000;
   endtask

   // Drive one cycle of input; the model records the word if the model says the FIFO has room.
   task automatic tick(input logic v, input logic [31:0] d);
      logic [19:0] e;
      e = expect_at(cyc);
      in_valid = v;
      in_data  = d;
      if (v && e[0] && !in_rst) begin
         w_data.push_back(d);
         w_acc.push_back(cyc + 1);
         last_start = (cyc + 2 > last_start + L) ? cyc + 2 : last_start + L;
         w_start.push_back(last_start);
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [19:0] got;
      resetb = 1'b0;
      in_rst = 1'b1;
      clear_model();
      repeat (3) tick(1'b0, '0);
      got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
      n_tests++;
      if (got !== {8'h00, 8'hFF, 4'b0001}) begin
         n_fail++;
         $display("FAIL reset_values got=%h required=%h", got, {8'h00, 8'hFF, 4'b0001});
      end
      resetb = 1'b1;
      in_rst = 1'b0;
      rel_c  = cyc;
      #1;
      n_tests++;
      if (io_oeb !== 8'hFF) begin
         n_fail++;
         $display("FAIL oeb_before_edge got=%h required=ff", io_oeb);
      end
      tick(1'b0, '0);
      n_tests++;
      if (io_oeb !== 8'h00 || io_out !== 8'h00) begin
         n_fail++;
         $display("FAIL oeb_after_release got oeb=%h out=%h required oeb=00 out=00", io_oeb, io_out);
      end
   endtask

   task automatic test_single_word;
      logic [19:0] got, e;
      logic [7:0] last_b;
      last_b = (NB == 5) ? 8'h08 : 8'h12;
      tick(1'b1, 32'h12345678);
      tick(1'b0, '0);
      n_tests++;
      if (io_out !== 8'h78 || byte_strobe !== 1'b1 || word_start !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency got out=%h strobe=%b ws=%b required out=78 strobe=1 ws=1", io_out, byte_strobe, word_start);
      end
      for (int i = 0; i < L + 3; i++) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL single_word cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         tick(1'b0, '0);
      end
      n_tests++;
      if (io_out !== last_b || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after got out=%h busy=%b required out=%h busy=0", io_out, busy, last_b);
      end
   endtask

   task automatic test_back_to_back;
      logic [19:0] got, e;
      logic [7:0] seq[$];
      logic [7:0] ref_seq[$];
      int str_cyc[$];
      int ws_cnt = 0;
      ref_seq = {8'h4F, 8'h00, 8'hA8, 8'hC1};
      if (NB == 5) ref_seq.push_back(8'h26);
      ref_seq = {ref_seq, 8'h83, 8'hF9, 8'hA2, 8'h3E};
      if (NB == 5) ref_seq.push_back(8'hE6);
      tick(1'b1, 32'hC1A8004F);
      tick(1'b1, 32'h3EA2F983);
      for (int i = 0; i < 2 * L + 4; i++) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         if (byte_strobe === 1'b1) begin
            seq.push_back(io_out);
            str_cyc.push_back(cyc);
         end
         if (word_start === 1'b1) ws_cnt++;
         tick(1'b0, '0);
      end
      n_tests++;
      if (ws_cnt != 2 || seq.size() != 2 * NB) begin
         n_fail++;
         $display("FAIL b2b_counts got ws=%0d bytes=%0d required ws=2 bytes=%0d", ws_cnt, seq.size(), 2 * NB);
      end else begin
         for (int i = 0; i < 2 * NB; i++) begin
            n_tests++;
            if (seq[i] !== ref_seq[i] || (i > 0 && str_cyc[i] - str_cyc[i-1] != H)) begin
               n_fail++;
               $display("FAIL b2b_byte%0d got=%h gap=%0d required=%h gap=%0d", i, seq[i],
                        (i > 0) ? str_cyc[i] - str_cyc[i-1] : H, ref_seq[i], H);
            end
         end
      end
   endtask

   task automatic test_full_fifo;
      logic [19:0] got, e;
      logic [31:0] words[6];
      int k = 0, guard = 0, n0;
      bit saw_full = 1'b0;
      foreach (words[i]) words[i] = $urandom;
      while (k < 6 && guard < 200) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL full_fifo cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         if (in_ready === 1'b0) saw_full = 1'b1;
         n0 = w_data.size();
         tick(1'b1, words[k]);
         if (w_data.size() != n0) k++;
         guard++;
      end
      n_tests++;
      if (k != 6 || !saw_full) begin
         n_fail++;
         $display("FAIL full_fifo_fill got accepted=%0d saw_not_ready=%0d required accepted=6 saw_not_ready=1", k, saw_full);
      end
      for (int i = 0; i < 6 * L + 4; i++) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL full_drain cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         tick(1'b0, '0);
      end
   endtask

   task automatic test_mid_reset;
      logic [19:0] got, e;
      int s0, strobes = 0;
      for (int i = 0; i < 4; i++) tick(1'b1, $urandom);
      s0 = w_start[w_start.size() - 4];
      while (cyc < s0 + 2 * H + 1) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL mid_reset_pre cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         tick(1'b0, '0);
      end
      resetb = 1'b0;
      #1;
      got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
      n_tests++;
      if (got !== {8'h00, 8'hFF, 4'b0001}) begin
         n_fail++;
         $display("FAIL mid_reset_immediate got=%h required=%h", got, {8'h00, 8'hFF, 4'b0001});
      end
      in_rst = 1'b1;
      clear_model();
      tick(1'b0, '0);
      tick(1'b0, '0);
      resetb = 1'b1;
      in_rst = 1'b0;
      rel_c  = cyc;
      for (int i = 0; i < 2 * L; i++) begin
         tick(1'b0, '0);
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL mid_reset_post cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         if (byte_strobe === 1'b1) strobes++;
      end
      n_tests++;
      if (strobes != 0) begin
         n_fail++;
         $display("FAIL mid_reset_residual got strobes=%0d required 0", strobes);
      end
   endtask

   task automatic test_hold1;
      logic [31:0] w;
      logic [7:0] b;
      w = 32'hAABBCCDD;
      in_valid1 = 1'b1;
      in_data1  = w;
      tick(1'b0, '0);
      in_valid1 = 1'b0;
      tick(1'b0, '0);
      for (int j = 0; j < NB; j++) begin
         b = byte_of(w, j);
         n_tests++;
         if (io_out1 !== b || byte_strobe1 !== 1'b1 || word_start1 !== (j == 0)) begin
            n_fail++;
            $display("FAIL hold1_byte%0d got out=%h str=%b ws=%b required out=%h str=1 ws=%0d", j, io_out1, byte_strobe1, word_start1, b, j == 0);
         end
         tick(1'b0, '0);
      end
      b = byte_of(w, NB - 1);
      n_tests++;
      if (io_out1 !== b || byte_strobe1 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL hold1_after got out=%h str=%b busy=%b required out=%h str=0 busy=0", io_out1, byte_strobe1, busy1, b);
      end
   endtask

   task automatic test_random;
      logic [19:0] got, e;
      int dens;
      for (int i = 0; i < 400 + 6 * L; i++) begin
         got = {io_out, io_oeb, byte_strobe, word_start, busy, in_ready};
         e   = expect_at(cyc);
         n_tests++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL random cyc=%0d {out,oeb,str,ws,busy,rdy} got=%h required=%h", cyc, got, e);
         end
         dens = ((i / 100) % 2 == 1) ? 1 : 5;
         tick(i < 400 && $urandom_range(0, dens) == 0, $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_full_fifo();
      test_mid_reset();
      test_hold1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
